// File: rtl/instr_store.sv
// Writable multi-bank instruction store with per-bank program length,
// registered one-cycle fetch and a background bank erase engine.
module instr_store #(
  parameter int unsigned IW = 8,
  parameter int unsigned AW = 5,
  parameter int unsigned NUM_BANKS = 2,
  parameter logic [IW-1:0] STOP_WORD = IW'(8'b11000011),
  localparam int unsigned BW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic          clk,
  input  logic          clear,
  input  logic          wr_en,
  input  logic [BW-1:0] wr_bank,
  input  logic [AW-1:0] wr_addr,
  input  logic [IW-1:0] wr_data,
  input  logic          rd_req,
  input  logic [BW-1:0] rd_bank,
  input  logic [AW-1:0] rd_addr,
  output logic [IW-1:0] instruction,
  output logic          rd_valid,
  output logic          past_end,
  input  logic          erase_en,
  input  logic [BW-1:0] erase_bank,
  output logic          busy,
  output logic [AW:0]   prog_len
);

  localparam int unsigned DEPTH = 2 ** AW;
  localparam int unsigned LW    = AW + 1;

  typedef enum logic {IDLE, ERASE} state_t;

  state_t        state, state_d;
  logic [IW-1:0] mem [NUM_BANKS][DEPTH];
  logic [LW-1:0] len [NUM_BANKS];
  logic [BW-1:0] ebank;
  logic [AW-1:0] ptr;

  logic          wr_ok_c, rd_ok_c, er_ok_c, rd_hit_c, start_c;
  logic [BW-1:0] wr_idx_c, rd_idx_c;
  logic [LW-1:0] rd_len_c, wr_end_c;

  // Bank validity and safe indices; an out-of-range bank never reaches the array.
  always_comb begin
    wr_ok_c  = wr_en && !busy && (32'(wr_bank) < NUM_BANKS);
    rd_ok_c  = 32'(rd_bank) < NUM_BANKS;
    er_ok_c  = 32'(erase_bank) < NUM_BANKS;
    wr_idx_c = wr_ok_c ? wr_bank : '0;
    rd_idx_c = rd_ok_c ? rd_bank : '0;
    rd_len_c = rd_ok_c ? len[rd_idx_c] : '0;
    rd_hit_c = rd_ok_c && (LW'(rd_addr) < rd_len_c);
    wr_end_c = LW'(wr_addr) + LW'(1);
  end

  assign prog_len = rd_len_c;

  always_ff @(posedge clk) begin
    if (clear) state <= IDLE;
    else       state <= state_d;
  end

  // Erase sequencing: the pointer runs 0..DEPTH-1 and stops on compare, not on wrap.
  always_comb begin
    state_d = state;
    start_c = 1'b0;
    case (state)
      IDLE: begin
        if (erase_en && er_ok_c) begin
          state_d = ERASE;
          start_c = 1'b1;
        end
      end
      ERASE: begin
        if (ptr == AW'(DEPTH - 1)) state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      for (int b = 0; b < int'(NUM_BANKS); b++) begin
        for (int a = 0; a < int'(DEPTH); a++) mem[b][a] <= STOP_WORD;
        len[b] <= '0;
      end
      instruction <= STOP_WORD;
      rd_valid    <= 1'b0;
      past_end    <= 1'b0;
      busy        <= 1'b0;
      ebank       <= '0;
      ptr         <= '0;
    end else begin
      // Fetch sees pre-edge memory and length, so a same-cycle write reads first.
      rd_valid <= rd_req;
      if (rd_req) begin
        instruction <= rd_hit_c ? mem[rd_idx_c][rd_addr] : STOP_WORD;
        past_end    <= !rd_hit_c;
      end
      if (wr_ok_c) begin
        mem[wr_idx_c][wr_addr] <= wr_data;
        if (wr_end_c > len[wr_idx_c]) len[wr_idx_c] <= wr_end_c;
      end
      if (start_c) begin
        ebank           <= erase_bank;
        ptr             <= '0;
        len[erase_bank] <= '0;
      end
      if (state == ERASE) begin
        mem[ebank][ptr] <= STOP_WORD;
        ptr             <= ptr + AW'(1);
      end
      busy <= (state_d == ERASE);
    end
  end

endmodule

// File: tb/tb_instr_store.sv
// Directed bench for instr_store: vector table for load/fetch/collision,
// hand sequences for erase, reset-during-erase and invalid banks.
module tb_instr_store;

  logic       clk = 1'b0;
  logic       clear;
  logic       wr_en, rd_req, erase_en;
  logic [0:0] wr_bank, rd_bank, erase_bank;
  logic [4:0] wr_addr, rd_addr;
  logic [7:0] wr_data, instruction;
  logic       rd_valid, past_end, busy;
  logic [5:0] prog_len;

  logic       x_wr_en, x_rd_req, x_erase_en;
  logic [1:0] x_wr_bank, x_rd_bank, x_erase_bank;
  logic [4:0] x_wr_addr, x_rd_addr;
  logic [7:0] x_wr_data, x_instruction;
  logic       x_rd_valid, x_past_end, x_busy;
  logic [5:0] x_prog_len;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_i;
  logic       exp_p;

  always #5 clk = ~clk;

  instr_store dut (
    .clk(clk), .clear(clear), .wr_en(wr_en), .wr_bank(wr_bank), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_req(rd_req), .rd_bank(rd_bank), .rd_addr(rd_addr),
    .instruction(instruction), .rd_valid(rd_valid), .past_end(past_end),
    .erase_en(erase_en), .erase_bank(erase_bank), .busy(busy), .prog_len(prog_len)
  );

  instr_store #(.NUM_BANKS(3)) dut3 (
    .clk(clk), .clear(clear), .wr_en(x_wr_en), .wr_bank(x_wr_bank), .wr_addr(x_wr_addr),
    .wr_data(x_wr_data), .rd_req(x_rd_req), .rd_bank(x_rd_bank), .rd_addr(x_rd_addr),
    .instruction(x_instruction), .rd_valid(x_rd_valid), .past_end(x_past_end),
    .erase_en(x_erase_en), .erase_bank(x_erase_bank), .busy(x_busy), .prog_len(x_prog_len)
  );

  typedef struct {
    logic       we;
    logic [0:0] wb;
    logic [4:0] wa;
    logic [7:0] wd;
    logic       re;
    logic [0:0] rb;
    logic [4:0] ra;
    logic [7:0] ei;
    logic       ep;
    logic [5:0] el;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic we, input logic [0:0] wb, input logic [4:0] wa,
                              input logic [7:0] wd, input logic re, input logic [0:0] rb,
                              input logic [4:0] ra, input logic [7:0] ei, input logic ep,
                              input logic [5:0] el);
    vec_t v;
    v.we = we; v.wb = wb; v.wa = wa; v.wd = wd;
    v.re = re; v.rb = rb; v.ra = ra;
    v.ei = ei; v.ep = ep; v.el = el;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    wr_en = 1'b0; wr_bank = '0; wr_addr = '0; wr_data = '0;
    rd_req = 1'b0; rd_bank = '0; rd_addr = '0;
    erase_en = 1'b0; erase_bank = '0;
  endtask

  task automatic x_idle();
    x_wr_en = 1'b0; x_wr_bank = '0; x_wr_addr = '0; x_wr_data = '0;
    x_rd_req = 1'b0; x_rd_bank = '0; x_rd_addr = '0;
    x_erase_en = 1'b0; x_erase_bank = '0;
  endtask

  // Drive one vector for a cycle, then check the registered fetch result and prog_len.
  task automatic step(input string nm, input vec_t v);
    @(negedge clk);
    idle_inputs();
    wr_en = v.we; wr_bank = v.wb; wr_addr = v.wa; wr_data = v.wd;
    rd_req = v.re; rd_bank = v.rb; rd_addr = v.ra;
    @(posedge clk);
    #1;
    if (v.re) begin
      exp_i = v.ei;
      exp_p = v.ep;
    end
    check({nm, " rd_valid"}, 32'(rd_valid), 32'(v.re));
    check({nm, " instruction"}, 32'(instruction), 32'(exp_i));
    check({nm, " past_end"}, 32'(past_end), 32'(exp_p));
    check({nm, " prog_len"}, 32'(prog_len), 32'(v.el));
  endtask

  task automatic x_step(input logic we, input logic [1:0] wb, input logic [7:0] wd,
                        input logic re, input logic [1:0] rb, input logic ee);
    @(negedge clk);
    x_idle();
    x_wr_en = we; x_wr_bank = wb; x_wr_data = wd;
    x_rd_req = re; x_rd_bank = rb;
    x_erase_en = ee; x_erase_bank = wb;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] fib [9];
    int busy_cnt;
    int first_idle;

    fib = '{8'h49, 8'h27, 8'h39, 8'h18, 8'h07, 8'h32, 8'h2D, 8'h18, 8'hC3};
    idle_inputs();
    x_idle();
    clear = 1'b0;

    // Reset for one cycle
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    #1;
    check("reset instruction", 32'(instruction), 32'h0C3);
    check("reset rd_valid", 32'(rd_valid), 32'd0);
    check("reset past_end", 32'(past_end), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    exp_i = 8'hC3;
    exp_p = 1'b0;
    @(negedge clk);
    clear = 1'b0;

    // Vector table: reset fetch, Fibonacci load, bank isolation, collisions
    vq.push_back(mk(0, 0, 0, 0, 1, 0, 0, 8'hC3, 1, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0));
    for (int i = 0; i < 9; i++) vq.push_back(mk(1, 0, 5'(i), fib[i], 0, 0, 0, 8'h00, 0, 6'(i + 1)));
    for (int i = 0; i < 9; i++) vq.push_back(mk(0, 0, 0, 0, 1, 0, 5'(i), fib[i], 0, 9));
    vq.push_back(mk(0, 0, 0, 0, 1, 0, 9, 8'hC3, 1, 9));
    vq.push_back(mk(1, 1, 20, 8'h27, 0, 1, 0, 8'h00, 0, 21));
    vq.push_back(mk(0, 0, 0, 0, 1, 1, 5, 8'hC3, 0, 21));
    vq.push_back(mk(0, 0, 0, 0, 1, 1, 20, 8'h27, 0, 21));
    vq.push_back(mk(0, 0, 0, 0, 1, 0, 0, 8'h49, 0, 9));
    vq.push_back(mk(0, 0, 0, 0, 1, 0, 7, 8'h18, 0, 9));
    vq.push_back(mk(1, 0, 3, 8'hAA, 1, 0, 3, 8'h18, 0, 9));
    vq.push_back(mk(0, 0, 0, 0, 1, 0, 3, 8'hAA, 0, 9));
    vq.push_back(mk(1, 0, 9, 8'h5A, 1, 0, 9, 8'hC3, 1, 10));
    vq.push_back(mk(0, 0, 0, 0, 1, 0, 9, 8'h5A, 0, 10));
    vq.push_back(mk(0, 0, 0, 0, 1, 1, 0, 8'hC3, 0, 21));
    foreach (vq[k]) step($sformatf("vec%0d", k), vq[k]);

    // Erase bank 0 with fetches and dropped writes in flight
    busy_cnt = 0;
    first_idle = -1;
    for (int c = 0; c < 34; c++) begin
      @(negedge clk);
      idle_inputs();
      case (c)
        0: begin erase_en = 1'b1; erase_bank = 1'b0; end
        3: begin rd_req = 1'b1; rd_bank = 1'b0; rd_addr = 5'd1; end
        5: begin rd_req = 1'b1; rd_bank = 1'b1; rd_addr = 5'd20; end
        7: begin
          wr_en = 1'b1; wr_bank = 1'b1; wr_addr = 5'd0; wr_data = 8'h55;
          erase_en = 1'b1; erase_bank = 1'b1;
        end
        9: begin wr_en = 1'b1; wr_bank = 1'b0; wr_addr = 5'd2; wr_data = 8'h66; end
        default: ;
      endcase
      @(posedge clk);
      #1;
      if (busy) busy_cnt++;
      else if (first_idle < 0) first_idle = c;
      if (c == 3) begin
        check("erase fetch b0 instruction", 32'(instruction), 32'h0C3);
        check("erase fetch b0 past_end", 32'(past_end), 32'd1);
        check("erase fetch b0 rd_valid", 32'(rd_valid), 32'd1);
        check("erase b0 prog_len", 32'(prog_len), 32'd0);
      end
      if (c == 5) begin
        check("erase fetch b1 instruction", 32'(instruction), 32'h027);
        check("erase fetch b1 past_end", 32'(past_end), 32'd0);
        exp_i = 8'h27;
        exp_p = 1'b0;
      end
    end
    check("erase busy cycles", 32'(busy_cnt), 32'd32);
    check("erase busy fall cycle", 32'(first_idle), 32'd32);

    // Dropped writes stayed dropped; erase cleared every written entry
    step("post-erase b0 len", mk(0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0));
    step("post-erase b1 a0", mk(0, 0, 0, 0, 1, 1, 0, 8'hC3, 0, 21));
    step("post-erase wr b0 a31", mk(1, 0, 31, 8'h11, 0, 0, 0, 8'h00, 0, 32));
    for (int a = 0; a < 32; a++)
      step($sformatf("post-erase b0 a%0d", a),
           mk(0, 0, 0, 0, 1, 0, 5'(a), (a == 31) ? 8'h11 : 8'hC3, 0, 32));

    // Reset at erase cycle 10 of bank 1
    for (int c = 0; c <= 10; c++) begin
      @(negedge clk);
      idle_inputs();
      if (c == 0) begin erase_en = 1'b1; erase_bank = 1'b1; end
      if (c == 5) begin rd_req = 1'b1; rd_bank = 1'b0; rd_addr = 5'd31; end
      if (c == 10) clear = 1'b1;
      @(posedge clk);
      #1;
      if (c == 1) check("erase2 busy", 32'(busy), 32'd1);
      if (c == 5) check("erase2 fetch instruction", 32'(instruction), 32'h011);
    end
    check("clear mid-erase busy", 32'(busy), 32'd0);
    check("clear mid-erase instruction", 32'(instruction), 32'h0C3);
    check("clear mid-erase rd_valid", 32'(rd_valid), 32'd0);
    exp_i = 8'hC3;
    exp_p = 1'b0;
    @(negedge clk);
    clear = 1'b0;
    step("cleared b0 a31", mk(0, 0, 0, 0, 1, 0, 31, 8'hC3, 1, 0));
    step("cleared b0 a0", mk(0, 0, 0, 0, 1, 0, 0, 8'hC3, 1, 0));
    step("cleared b1 a20", mk(0, 0, 0, 0, 1, 1, 20, 8'hC3, 1, 0));
    check("cleared busy", 32'(busy), 32'd0);

    // Three-bank instance: bank 3 is invalid for write, fetch and erase
    x_step(1, 2'd3, 8'h12, 0, 2'd3, 0);
    check("nb3 bank3 prog_len", 32'(x_prog_len), 32'd0);
    x_step(0, 2'd0, 8'h00, 1, 2'd3, 0);
    check("nb3 bank3 instruction", 32'(x_instruction), 32'h0C3);
    check("nb3 bank3 past_end", 32'(x_past_end), 32'd1);
    check("nb3 bank3 rd_valid", 32'(x_rd_valid), 32'd1);
    x_step(0, 2'd0, 8'h00, 1, 2'd0, 0);
    check("nb3 bank0 past_end", 32'(x_past_end), 32'd1);
    check("nb3 bank0 prog_len", 32'(x_prog_len), 32'd0);
    x_step(1, 2'd2, 8'h12, 0, 2'd2, 0);
    check("nb3 bank2 prog_len", 32'(x_prog_len), 32'd1);
    x_step(0, 2'd0, 8'h00, 1, 2'd2, 0);
    check("nb3 bank2 instruction", 32'(x_instruction), 32'h012);
    check("nb3 bank2 past_end", 32'(x_past_end), 32'd0);
    x_step(0, 2'd3, 8'h00, 0, 2'd0, 1);
    check("nb3 bank3 erase ignored", 32'(x_busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/instr_store.md
# instr_store

Parametrised, writable multi-bank instruction store that replaces the fixed per-test instruction tables feeding the CPU fetch stage. Programs are loaded over a write port into one of NUM_BANKS banks, fetched with a one-cycle registered read handshake, and bounded by a per-bank program length: fetches past the end return the stop word. A background erase engine refills a whole bank with the stop word.

## Interface
Parameters:
- IW, 8, instruction width in bits
- AW, 5, address width; bank depth DEPTH = 2**AW
- NUM_BANKS, 2, number of program banks; BW = max(1, clog2(NUM_BANKS))
- STOP_WORD, 8'b11000011, stop instruction; the reset and fill value of every entry

Ports:
- clk  in  1  clock; all state updates on rising edge
- clear  in  1  synchronous, active-high reset
- wr_en  in  1  write strobe
- wr_bank  in  BW  write bank
- wr_addr  in  AW  write address
- wr_data  in  IW  write data
- rd_req  in  1  fetch request
- rd_bank  in  BW  fetch bank
- rd_addr  in  AW  fetch address
- instruction  out  IW  fetched instruction, registered
- rd_valid  out  1  one-cycle pulse marking a valid `instruction`
- past_end  out  1  registered with `instruction`; fetch was at or beyond the program length, or targeted an invalid bank
- erase_en  in  1  start erase of erase_bank; sampled only when idle
- erase_bank  in  BW  bank to erase
- busy  out  1  erase in progress
- prog_len  out  AW+1  length of bank rd_bank, combinational from the length registers

## Operation
- Storage: NUM_BANKS x DEPTH x IW flip-flop array, plus one len[b] register (AW+1 bits) per bank.
- Reset (`clear` high at an edge) wins over everything else in that cycle. All entries become STOP_WORD. All len = 0. instruction = STOP_WORD. rd_valid = 0. past_end = 0. busy = 0. The FSM goes to IDLE.
- Write: if wr_en, !busy and wr_bank < NUM_BANKS, then mem[wr_bank][wr_addr] <= wr_data and len[wr_bank] <= max(len, wr_addr+1). Otherwise the write is silently dropped.
- Fetch: when rd_req is high, the next edge loads `instruction` and `past_end` and pulses rd_valid.
  - If rd_bank is invalid, or rd_addr >= len[rd_bank]: instruction = STOP_WORD, past_end = 1.
  - Otherwise: instruction = mem[rd_bank][rd_addr], past_end = 0.
  - When rd_req is low: rd_valid = 0, and instruction and past_end hold their values.
- Read and write to the same entry in the same cycle: the read returns the old data and the old-length check (read-first).
- Erase FSM, states IDLE and ERASE:
  - IDLE -> ERASE on erase_en with erase_bank valid. On that edge: latch the bank, set ptr = 0, set len[bank] = 0, set busy = 1. An invalid erase_bank is ignored.
  - ERASE: one entry per cycle, mem[bank][ptr] <= STOP_WORD, then ptr++. After the write at ptr = DEPTH-1, return to IDLE and set busy = 0.
  - erase_en is ignored while busy.
  - Fetches are served during erase. Any fetch of the erasing bank returns STOP_WORD with past_end = 1, because len is already 0.
- Reset in ERASE aborts the erase immediately. The full reset fill makes the result consistent.
- The pointer wrap is width-safe: the counter is AW bits, with termination decided by ptr == DEPTH-1, not by overflow.

## Timing
- Write latency: 1 cycle. Data and len are visible to a fetch requested on the following cycle.
- Fetch latency: 1 cycle, from rd_req at edge N to instruction/rd_valid valid after edge N. Back-to-back requests give one result per cycle.
- Erase: busy rises at the edge that samples erase_en and falls DEPTH edges later (32 cycles at defaults). A new write is accepted on the first cycle with busy = 0.
- prog_len is combinational and has no latency relative to the len registers.
- After clear deasserts, the first write or fetch can occur on the next edge.

## Test plan
- Reset check: assert clear for 1 cycle, then fetch bank 0 at addr 0 → instruction = 8'hC3, past_end = 1, rd_valid pulses once, prog_len = 0.
- Fibonacci load:
  - Write bank 0 at addrs 0–8 with 49, 27, 39, 18, 07, 32, 2D, 18, C3 (hex), then fetch addrs 0–9 back to back.
  - Required: the same nine words at one per cycle with past_end = 0; addr 9 gives C3 with past_end = 1; prog_len = 9.
- Bank isolation and sparse length: write bank 1 at addr 20 = 8'h27.
  - Bank 1: prog_len = 21; addr 5 → C3, past_end = 0; addr 20 → 27.
  - Bank 0 is unchanged.
- Same-cycle collision: bank 0 at addr 3 holds 18. In one cycle, write 8'hAA to it and fetch it → 18. The next fetch → AA.
- Erase:
  - erase_en on bank 0 → busy high for exactly 32 cycles.
  - A mid-erase fetch of bank 0 at addr 1 → C3, past_end = 1.
  - A mid-erase fetch of bank 1 at addr 20 → 27.
  - A write issued while busy is dropped.
  - After erase, every bank 0 entry reads C3.
- Reset mid-erase and invalid bank:
  - Assert clear at erase cycle 10 → busy = 0 next cycle, and all banks read C3 with len = 0.
  - With NUM_BANKS = 3, writing to bank 3 is dropped, and fetching bank 3 gives C3 with past_end = 1.
